// File: rtl/udp_xmit.sv
// udp_xmit: buffers one payload frame, then streams UDP header (zero checksum) plus payload.
module udp_xmit #(
    parameter int ADDR_W = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] src_port,
    input  logic [15:0] dest_port,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        udp_valid,
    output logic [31:0] udp_data,
    output logic        udp_last,
    input  logic        udp_ready,
    output logic [15:0] udp_length,
    output logic        truncated
);
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] FULL_M1 = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {ACCUM, HDR0, HDR1, PAYLOAD} state_t;

    state_t state, state_n;
    logic [31:0] mem [DEPTH];
    logic [ADDR_W:0] count, rd;
    logic accept, close, adv, load;

    assign in_ready = state == ACCUM && count < DEPTH;
    assign accept   = in_valid && in_ready;
    assign close    = accept && (in_last || count == FULL_M1);
    assign adv      = udp_valid && udp_ready;
    // Payload words are fetched into the output register one transfer ahead, so no bubbles.
    assign load     = adv && (state == HDR1 || (state == PAYLOAD && !udp_last));

    always_ff @(posedge clk) begin
        if (reset)
            state <= ACCUM;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ACCUM:   state_n = close ? HDR0 : ACCUM;
            HDR0:    state_n = adv ? HDR1 : HDR0;
            HDR1:    state_n = adv ? PAYLOAD : HDR1;
            PAYLOAD: state_n = adv && udp_last ? ACCUM : PAYLOAD;
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[count[ADDR_W-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            udp_valid  <= 1'b0;
            udp_data   <= '0;
            udp_last   <= 1'b0;
            udp_length <= '0;
            truncated  <= 1'b0;
            count      <= '0;
            rd         <= '0;
        end else begin
            truncated <= close && !in_last;
            if (accept)
                count <= count + 1'b1;
            if (close) begin
                udp_valid  <= 1'b1;
                udp_data   <= {src_port, dest_port};
                udp_length <= 16'({count + 1'b1, 2'b00}) + 16'd8;
            end
            if (state == HDR0 && adv)
                udp_data <= {udp_length, 16'h0000};
            if (load) begin
                udp_data <= mem[rd[ADDR_W-1:0]];
                udp_last <= rd + 1'b1 == count;
                rd       <= rd + 1'b1;
            end
            if (state == PAYLOAD && adv && udp_last) begin
                udp_valid <= 1'b0;
                udp_last  <= 1'b0;
                count     <= '0;
                rd        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_udp_xmit.sv
// tb_udp_xmit: randomized frames checked against a queue-based datagram model.
module tb_udp_xmit;
    localparam int AW = 9;
    localparam int DEPTH = 1 << AW;

    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] src_port = '0, dest_port = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, udp_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, udp_valid, udp_last, truncated;
    logic [31:0] udp_data;
    logic [15:0] udp_length;
    int n_cmp = 0, n_bad = 0, trunc_cnt = 0;

    udp_xmit #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .src_port(src_port), .dest_port(dest_port),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .udp_valid(udp_valid), .udp_data(udp_data), .udp_last(udp_last), .udp_ready(udp_ready),
        .udp_length(udp_length), .truncated(truncated)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!reset && truncated) trunc_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Datagram as the IP layer should see it: two header words, then the payload.
    function automatic wq_t model(input wq_t pay, input logic [15:0] s, input logic [15:0] d);
        wq_t q;
        int n = pay.size();
        q.push_back({s, d});
        q.push_back({16'(n * 4 + 8), 16'h0000});
        foreach (pay[i]) q.push_back(pay[i]);
        return q;
    endfunction

    function automatic wq_t rand_pay(input int n);
        wq_t q;
        for (int i = 0; i < n; i++) q.push_back($urandom);
        return q;
    endfunction

    task automatic send(input wq_t pay, input bit mark_last, input logic [15:0] s,
                        input logic [15:0] d, input int gap_pct);
        for (int i = 0; i < pay.size(); i++) begin
            int t = 0;
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid  = 1'b1;
            in_data   = pay[i];
            in_last   = mark_last && i == pay.size() - 1;
            src_port  = s;
            dest_port = d;
            @(negedge clk);
            while (!in_ready && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 5000) begin
                chk("in_ready_timeout", in_ready, 1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input wq_t exp, input int stall_pct, input bit exp_trunc, input int max_x);
        int k = 0, t = 0, t0 = trunc_cnt;
        bit started = 0, prev_stall = 0;
        logic [31:0] prev_d = '0;
        logic prev_l = 1'b0;
        while (k < max_x && k < exp.size() && t < 20000) begin
            udp_ready = int'($urandom_range(99)) >= stall_pct;
            @(negedge clk);
            t++;
            if (udp_valid) begin
                if (!started) chk("trunc_at_hdr0", truncated, exp_trunc);
                started = 1;
                if (prev_stall) begin
                    chk("hold_data", udp_data, prev_d);
                    chk("hold_last", udp_last, prev_l);
                end
                chk("in_ready_busy", in_ready, 0);
                if (udp_ready) begin
                    chk("word", udp_data, exp[k]);
                    chk("last", udp_last, k == exp.size() - 1);
                    chk("length", udp_length, exp[1][31:16]);
                    k++;
                end
                prev_stall = !udp_ready;
                prev_d = udp_data;
                prev_l = udp_last;
            end else if (started) begin
                chk("no_bubble", udp_valid, 1);
            end
            @(posedge clk); #1;
        end
        if (t >= 20000) chk("recv_timeout", k, exp.size());
        if (k == exp.size()) begin
            @(negedge clk);
            chk("valid_drop", udp_valid, 0);
            chk("last_drop", udp_last, 0);
            chk("in_ready_back", in_ready, 1);
            chk("trunc_pulses", trunc_cnt - t0, exp_trunc);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        wq_t p, p2;
        logic [15:0] s, d;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", udp_valid, 0);
        chk("rst_data", udp_data, 0);
        chk("rst_last", udp_last, 0);
        chk("rst_length", udp_length, 0);
        chk("rst_trunc", truncated, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        p = rand_pay(3);
        fork send(p, 1, 16'h1234, 16'h5678, 0); recv(model(p, 16'h1234, 16'h5678), 0, 0, 1000); join
        fork send(p, 1, 16'h1234, 16'h5678, 0); recv(model(p, 16'h1234, 16'h5678), 45, 0, 1000); join
        p = rand_pay(1);
        fork send(p, 1, 16'h1234, 16'h5678, 0); recv(model(p, 16'h1234, 16'h5678), 0, 0, 1000); join

        p = rand_pay(DEPTH);
        fork send(p, 0, 16'hAAAA, 16'h5555, 0); recv(model(p, 16'hAAAA, 16'h5555), 20, 1, 100000); join

        p = rand_pay(5);
        fork send(p, 1, 16'h0101, 16'h0202, 0); recv(model(p, 16'h0101, 16'h0202), 0, 0, 4); join
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", udp_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        p = rand_pay(2);
        fork send(p, 1, 16'h0303, 16'h0404, 0); recv(model(p, 16'h0303, 16'h0404), 0, 0, 1000); join

        p = rand_pay(4);
        p2 = rand_pay(3);
        fork
            begin send(p, 1, 16'h1111, 16'h2222, 0); send(p2, 1, 16'h3333, 16'h4444, 0); end
            begin recv(model(p, 16'h1111, 16'h2222), 30, 0, 1000); recv(model(p2, 16'h3333, 16'h4444), 30, 0, 1000); end
        join

        for (int f = 0; f < 15; f++) begin
            p = rand_pay(int'($urandom_range(1, 16)));
            s = 16'($urandom);
            d = 16'($urandom);
            fork send(p, 1, s, d, 30); recv(model(p, s, d), int'($urandom_range(0, 50)), 0, 1000); join
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/udp_xmit.md
Name: udp_xmit

Overview:
Transmit-side counterpart of the UDP receive path. Collects one application payload frame of 32-bit words into an internal buffer, then builds the 8-byte UDP header (source port, destination port, length, checksum). It streams header plus payload to the IP transmit layer over a valid/ready word interface. Checksum is not computed; the field is always transmitted as 16'h0000 (legal for UDP over IPv4).

Parameters:
ADDR_W, 9, log2 of payload buffer depth in 32-bit words (DEPTH = 2**ADDR_W = 512). Legal range 2..13, which keeps the length field within 16 bits.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
src_port  in  16  UDP source port; sampled on the cycle the frame closes
dest_port  in  16  UDP destination port; sampled on the cycle the frame closes
in_valid  in  1  application word valid
in_data  in  32  application payload word
in_last  in  1  marks the final payload word of the frame
in_ready  out  1  block can accept an application word
udp_valid  out  1  udp_data holds a valid output word
udp_data  out  32  header/payload word to IP transmit layer
udp_last  out  1  final word of the UDP datagram
udp_ready  in  1  IP layer accepts the current word
udp_length  out  16  datagram length in bytes; stable from first header word through last word
truncated  out  1  one-cycle pulse: frame closed because buffer filled without in_last

Behaviour:
- Reset: udp_valid=0, udp_data=0, udp_last=0, udp_length=0, truncated=0, in_ready=1. Word count and pointers cleared, state=ACCUM. A reset mid-collection or mid-transmit discards the frame; no partial output follows.
- States: ACCUM -> HDR0 -> HDR1 -> PAYLOAD -> ACCUM.
- ACCUM: in_ready=1 while count<DEPTH. A word is accepted when in_valid&&in_ready; it is written to buffer[count] and count increments.
- Frame close: the frame closes when an accepted word has in_last=1, or when the accepted word fills slot DEPTH-1 (count reaches DEPTH).
  - On close: latch src_port/dest_port. Compute n = total words; udp_length = n*4+8 (16-bit). Go to HDR0.
  - If closing on a full buffer without in_last: truncated pulses for 1 cycle, on the cycle after the close.
- in_ready=0 in HDR0, HDR1 and PAYLOAD. The block buffers one frame at a time.
- HDR0: udp_valid=1 on the cycle after close, udp_data={src_port,dest_port}.
- HDR1: udp_data={udp_length,16'h0000}.
- PAYLOAD: words are emitted in buffer order, 0..n-1. udp_last=1 only with word n-1.
- Output handshake:
  - A word transfers on udp_valid&&udp_ready.
  - While udp_valid&&!udp_ready, udp_data/udp_last/udp_valid hold stable.
  - udp_valid stays high, with no bubbles, from HDR0 until the last word transfers, provided udp_ready is high. If the buffer RAM is synchronous, the implementation prefetches to meet this.
- After the last word transfers: udp_valid=0 and udp_last=0 next cycle. count resets, state=ACCUM, in_ready=1 the same cycle udp_valid drops.
- udp_length holds its value until the next frame closes.
- Zero-payload datagrams cannot be generated; the minimum datagram is 1 word (udp_length=12).
- in_data/in_last are ignored when in_valid=0. in_valid while in_ready=0 is not accepted, and the source must hold it.

Test Plan:
- 3-word frame D0..D2, in_last on D2, src=0x1234, dst=0x5678, udp_ready=1 -> udp_data sequence 0x12345678, 0x00140000, D0, D1, D2. udp_last only on D2, udp_length=0x0014, udp_valid high 5 consecutive cycles.
- Same frame with udp_ready low for 3 cycles during HDR1 and again on D1 -> words held stable while stalled, order unchanged, no word dropped or duplicated.
- Single-word frame (in_last on first word) -> 0x12345678, 0x000C0000, D0 with udp_last; udp_length=12.
- ADDR_W=2, 4 words, in_last never asserted -> frame closes after word 4, truncated pulses once, udp_length=24, in_ready=0 until the last word transfers.
- Reset asserted during PAYLOAD after 2 of 5 words -> next cycle udp_valid=0, in_ready=1. A following 2-word frame transmits correctly with udp_length=16.
- Back-to-back frames with in_valid held high -> in_ready low throughout frame 1 transmit. Frame 2 header reflects ports sampled at frame 2 close.
